// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage controller (master) and data memory (slave).
interface mem_stage_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: turns EX/MEM load/store requests into data-memory bus
// transactions (IDLE -> REQ -> DONE), stalls the pipeline while the bus is busy,
// formats load data and reports alignment / bus-timeout exceptions.
module mem_stage_ctrl (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             EX_MEM_ALU_result_data,
    input  logic [31:0]             EX_MEM_Memory_Write_data_data,
    input  logic                    EX_MEM_MemRead_data,
    input  logic                    EX_MEM_MemWrite_data,
    input  logic [1:0]              EX_MEM_StoreType_data,
    input  logic [2:0]              EX_MEM_LoadType_data,
    input  logic [1:0]              EX_MEM_ExcCode_data,
    mem_stage_ctrl_if.master        dmem,
    output logic                    MEM_Stall,
    output logic [31:0]             MEM_Load_data,
    output logic [1:0]              MEM_ExcCode
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Last ack-less REQ cycle count value: abort after the 15th REQ cycle.
    localparam logic [3:0] TMO_LAST = 4'd14;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [3:0]  r_cnt;
    logic        r_tmo;
    logic [31:0] r_load;

    logic [1:0]  w_off;
    logic        w_is_ld;
    logic        w_align;
    logic        w_mem_op;
    logic        w_access;
    logic        w_misal;
    logic        w_in_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;

    assign w_off    = EX_MEM_ALU_result_data[1:0];
    assign w_is_ld  = EX_MEM_MemRead_data & ~EX_MEM_MemWrite_data;
    assign w_mem_op = (EX_MEM_MemRead_data | EX_MEM_MemWrite_data) & (EX_MEM_ExcCode_data == 2'b00);
    assign w_access = w_mem_op & w_align;
    assign w_misal  = w_mem_op & ~w_align;
    assign w_in_req = (r_state == S_REQ);

    // Alignment check by access size; a store decides the size when both are set.
    always_comb begin
        w_align = (w_off == 2'b00);
        if (EX_MEM_MemWrite_data) begin
            case (EX_MEM_StoreType_data)
                2'b01:   w_align = ~w_off[0];
                2'b10:   w_align = 1'b1;
                default: w_align = (w_off == 2'b00);
            endcase
        end else begin
            case (EX_MEM_LoadType_data)
                3'b001, 3'b010: w_align = ~w_off[0];
                3'b011, 3'b100: w_align = 1'b1;
                default:        w_align = (w_off == 2'b00);
            endcase
        end
    end

    // Byte lanes and replicated write data for the store width; loads read the full word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = EX_MEM_Memory_Write_data_data;
        case (EX_MEM_StoreType_data)
            2'b01: w_wdata = {2{EX_MEM_Memory_Write_data_data[15:0]}};
            2'b10: w_wdata = {4{EX_MEM_Memory_Write_data_data[7:0]}};
            default: ;
        endcase
        if (EX_MEM_MemWrite_data) begin
            case (EX_MEM_StoreType_data)
                2'b01:   w_be = w_off[1] ? 4'b1100 : 4'b0011;
                2'b10:   w_be = 4'b0001 << w_off;
                default: w_be = 4'b1111;
            endcase
        end
    end

    // Lane select and sign/zero extension of the returned word.
    always_comb begin
        case (w_off)
            2'b00:   w_byte = dmem.dmem_rdata[7:0];
            2'b01:   w_byte = dmem.dmem_rdata[15:8];
            2'b10:   w_byte = dmem.dmem_rdata[23:16];
            default: w_byte = dmem.dmem_rdata[31:24];
        endcase
        w_half = w_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (EX_MEM_LoadType_data)
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_fmt = {16'h0000, w_half};
            3'b011:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_fmt = {24'h000000, w_byte};
            default: w_load_fmt = dmem.dmem_rdata;
        endcase
    end

    // Next-state: ack wins over the timeout in the final REQ cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_access) w_next = S_REQ;
            S_REQ:   if (dmem.dmem_ack || (r_cnt == TMO_LAST)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Timeout counter/flag: cleared while idle, so every REQ entry starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_tmo <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 4'd0;
                    r_tmo <= 1'b0;
                end
                S_REQ: if (!dmem.dmem_ack) begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == TMO_LAST) r_tmo <= 1'b1;
                end
                default: r_tmo <= 1'b0;
            endcase
        end
    end

    // Load result captured only on an acked load; held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    r_load <= 32'h0;
        else if (w_in_req && dmem.dmem_ack && w_is_ld) r_load <= w_load_fmt;
    end

    assign dmem.dmem_req   = w_in_req;
    assign dmem.dmem_we    = w_in_req & EX_MEM_MemWrite_data;
    assign dmem.dmem_be    = w_in_req ? w_be : 4'b0000;
    assign dmem.dmem_addr  = {EX_MEM_ALU_result_data[31:2], 2'b00};
    assign dmem.dmem_wdata = w_wdata;

    // Stall is masked by reset so it drops immediately, without waiting for a clock.
    assign MEM_Stall     = reset & (((r_state == S_IDLE) & w_access) | w_in_req);
    assign MEM_Load_data = r_load;

    // Exception priority: upstream, then misalignment (idle only), then timeout in DONE.
    always_comb begin
        MEM_ExcCode = 2'b00;
        if (EX_MEM_ExcCode_data != 2'b00)
            MEM_ExcCode = EX_MEM_ExcCode_data;
        else if (reset && (r_state == S_IDLE) && w_misal)
            MEM_ExcCode = EX_MEM_MemWrite_data ? 2'b10 : 2'b01;
        else if ((r_state == S_DONE) && r_tmo)
            MEM_ExcCode = 2'b11;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, random
// transactions against a size/offset-arithmetic reference model, plus
// reset-at-start and reset-mid-request sequences.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu, wd;
    logic        rd, wr;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic [1:0]  exin;
    logic        stall;
    logic [31:0] ld;
    logic [1:0]  exc;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_id  = 0;
    logic [31:0] m_load;

    always #5 clk = ~clk;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl dut (
        .clk                           (clk),
        .reset                         (reset),
        .EX_MEM_ALU_result_data        (alu),
        .EX_MEM_Memory_Write_data_data (wd),
        .EX_MEM_MemRead_data           (rd),
        .EX_MEM_MemWrite_data          (wr),
        .EX_MEM_StoreType_data         (st),
        .EX_MEM_LoadType_data          (lt),
        .EX_MEM_ExcCode_data           (exin),
        .dmem                          (bus),
        .MEM_Stall                     (stall),
        .MEM_Load_data                 (ld),
        .MEM_ExcCode                   (exc)
    );

    typedef struct {
        logic [31:0] addr, wd;
        logic        rd, wr;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [1:0]  exin;
        logic [31:0] rdata;
        int          dly;     // REQ cycle index carrying ack; >=15 means never
        logic        acc;
        logic [1:0]  exc;     // idle code if no access, DONE code otherwise
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdat, load;
        logic        upd;
        int          nreq;
    } vec_t;

    vec_t tab [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %h expected %h", nm, cur_id, act, exp);
        end
    endtask

    function automatic vec_t tv(input logic [31:0] a, d, input logic r, w, input logic [1:0] s,
                                input logic [2:0] l, input logic [1:0] e, input logic [31:0] rdat,
                                input int dl, input logic acc, input logic [1:0] ex, input logic we,
                                input logic [3:0] be, input logic [31:0] wdt, lval, input logic up,
                                input int nr);
        vec_t v;
        v.addr = a; v.wd = d; v.rd = r; v.wr = w; v.st = s; v.lt = l; v.exin = e;
        v.rdata = rdat; v.dly = dl; v.acc = acc; v.exc = ex; v.we = we; v.be = be;
        v.wdat = wdt; v.load = lval; v.upd = up; v.nreq = nr;
        return v;
    endfunction

    // Reference model: access size and byte offset, then plain shifts and masks.
    function automatic vec_t model(input vec_t vin);
        vec_t v;
        int sz, off;
        logic [31:0] mask, val;
        v = vin;
        off = int'(v.addr[1:0]);
        if (v.wr) sz = (v.st == 2'd1) ? 2 : (v.st == 2'd2) ? 1 : 4;
        else      sz = (v.lt == 3'd1 || v.lt == 3'd2) ? 2 : (v.lt == 3'd3 || v.lt == 3'd4) ? 1 : 4;
        v.acc = 1'b0; v.we = 1'b0; v.be = 4'h0; v.wdat = 32'h0; v.load = 32'h0;
        v.upd = 1'b0; v.nreq = 0;
        if (v.exin != 2'b00)      v.exc = v.exin;
        else if (!(v.rd || v.wr)) v.exc = 2'b00;
        else if ((off % sz) != 0) v.exc = v.wr ? 2'b10 : 2'b01;
        else begin
            v.acc  = 1'b1;
            v.we   = v.wr;
            v.be   = v.wr ? 4'(((1 << sz) - 1) << off) : 4'hF;
            v.wdat = (sz == 4) ? v.wd : (sz == 2) ? {16'h0, v.wd[15:0]} * 32'h00010001
                                                  : {24'h0, v.wd[7:0]} * 32'h01010101;
            mask = (sz == 4) ? 32'hFFFFFFFF : (sz == 2) ? 32'h0000FFFF : 32'h000000FF;
            val  = (v.rdata >> (8 * off)) & mask;
            if ((v.lt == 3'd1 || v.lt == 3'd3) && val[8*sz-1]) val = val | ~mask;
            v.load = val;
            v.upd  = !v.wr && (v.dly < 15);
            v.nreq = (v.dly < 15) ? v.dly + 1 : 15;
            v.exc  = (v.dly < 15) ? 2'b00 : 2'b11;
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        alu = v.addr; wd = v.wd; rd = v.rd; wr = v.wr; st = v.st; lt = v.lt; exin = v.exin;
    endtask

    task automatic clear_inputs();
        rd = 1'b0; wr = 1'b0; exin = 2'b00;
    endtask

    // Called at posedge+1 with the DUT idle; leaves it idle at posedge+1.
    task automatic run_txn(input vec_t v);
        int n;
        drive(v);
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'(v.acc));
        chk("idle_req", 32'(bus.dmem_req), 32'd0);
        chk("idle_exc", 32'(exc), v.acc ? 32'd0 : 32'(v.exc));
        if (!v.acc) begin
            chk("idle_load_hold", ld, m_load);
            @(posedge clk); #1;
            clear_inputs();
            return;
        end
        @(posedge clk); #1;
        for (n = 0; n < 20; n++) begin
            bus.dmem_rdata = v.rdata;
            bus.dmem_ack   = (n == v.dly);
            @(negedge clk);
            if (!bus.dmem_req) break;
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_addr", bus.dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk("req_be", 32'(bus.dmem_be), 32'(v.be));
            chk("req_we", 32'(bus.dmem_we), 32'(v.we));
            chk("req_exc", 32'(exc), 32'd0);
            if (v.we) chk("req_wdata", bus.dmem_wdata, v.wdat);
            @(posedge clk); #1;
        end
        bus.dmem_ack = 1'b0;
        chk("req_cycles", 32'(n), 32'(v.nreq));
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(bus.dmem_req), 32'd0);
        chk("done_be", 32'(bus.dmem_be), 32'd0);
        chk("done_we", 32'(bus.dmem_we), 32'd0);
        chk("done_exc", 32'(exc), 32'(v.exc));
        if (v.upd) m_load = v.load;
        chk("done_load", ld, m_load);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tab[0]  = tv(32'h100, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 0,  1, 0, 0, 4'hF, 0, 32'hDEADBEEF, 1, 1);
        tab[1]  = tv(32'h103, 0, 1, 0, 0, 3, 0, 32'h80FFFFFF, 1,  1, 0, 0, 4'hF, 0, 32'hFFFFFF80, 1, 2);
        tab[2]  = tv(32'h103, 0, 1, 0, 0, 4, 0, 32'h80FFFFFF, 0,  1, 0, 0, 4'hF, 0, 32'h00000080, 1, 1);
        tab[3]  = tv(32'h102, 0, 1, 0, 0, 2, 0, 32'h80011234, 2,  1, 0, 0, 4'hF, 0, 32'h00008001, 1, 3);
        tab[4]  = tv(32'h102, 0, 1, 0, 0, 1, 0, 32'h80011234, 0,  1, 0, 0, 4'hF, 0, 32'hFFFF8001, 1, 1);
        tab[5]  = tv(32'h100, 0, 1, 0, 0, 1, 0, 32'h80011234, 0,  1, 0, 0, 4'hF, 0, 32'h00001234, 1, 1);
        tab[6]  = tv(32'h206, 32'h0000ABCD, 0, 1, 1, 0, 0, 0, 1,  1, 0, 1, 4'hC, 32'hABCDABCD, 0, 0, 2);
        tab[7]  = tv(32'h301, 32'h123456EF, 0, 1, 2, 0, 0, 0, 0,  1, 0, 1, 4'h2, 32'hEFEFEFEF, 0, 0, 1);
        tab[8]  = tv(32'h040, 32'hCAFEF00D, 0, 1, 0, 0, 0, 0, 3,  1, 0, 1, 4'hF, 32'hCAFEF00D, 0, 0, 4);
        tab[9]  = tv(32'h044, 32'h11223344, 0, 1, 3, 0, 0, 0, 0,  1, 0, 1, 4'hF, 32'h11223344, 0, 0, 1);
        tab[10] = tv(32'h101, 0, 1, 0, 0, 0, 0, 0, 0,             0, 1, 0, 4'h0, 0, 0, 0, 0);
        tab[11] = tv(32'h003, 0, 0, 1, 1, 0, 0, 0, 0,             0, 2, 0, 4'h0, 0, 0, 0, 0);
        tab[12] = tv(32'h100, 0, 1, 0, 0, 0, 3, 0, 0,             0, 3, 0, 4'h0, 0, 0, 0, 0);
        tab[13] = tv(32'h010, 0, 1, 0, 0, 7, 0, 32'h01020304, 0,  1, 0, 0, 4'hF, 0, 32'h01020304, 1, 1);
        tab[14] = tv(32'h001, 32'h000000A5, 1, 1, 2, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 1, 4'h2, 32'hA5A5A5A5, 0, 0, 1);
        tab[15] = tv(32'h200, 0, 1, 0, 0, 0, 0, 32'h12345678, 99, 1, 3, 0, 4'hF, 0, 0, 0, 15);
        tab[16] = tv(32'h204, 0, 1, 0, 0, 0, 0, 32'h55AA55AA, 14, 1, 0, 0, 4'hF, 0, 32'h55AA55AA, 1, 15);
        tab[17] = tv(32'h000, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 4'h0, 0, 0, 0, 0);

        // Reset held with a valid LW pending: everything quiet, passthrough live.
        reset = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        drive(tab[0]);
        m_load = 32'h0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_be", 32'(bus.dmem_be), 32'd0);
        chk("rst_load", ld, 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        exin = 2'b10;
        #1 chk("rst_exc_pass", 32'(exc), 32'd2);
        exin = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_req", 32'(bus.dmem_req), 32'd1);
        bus.dmem_rdata = 32'hDEADBEEF; bus.dmem_ack = 1'b1;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("first_done_stall", 32'(stall), 32'd0);
        chk("first_done_load", ld, 32'hDEADBEEF);
        m_load = 32'hDEADBEEF;
        @(posedge clk); #1;
        clear_inputs();

        for (int i = 0; i < 18; i++) begin
            cur_id = i;
            run_txn(tab[i]);
        end

        for (int i = 0; i < 60; i++) begin
            cur_id = 100 + i;
            v.addr  = $urandom;
            v.wd    = $urandom;
            v.rd    = 1'($urandom_range(0, 1));
            v.wr    = 1'($urandom_range(0, 1));
            v.st    = 2'($urandom_range(0, 3));
            v.lt    = 3'($urandom_range(0, 7));
            v.exin  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.rdata = $urandom;
            v.dly   = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
            run_txn(model(v));
        end

        // Reset asserted mid-cycle during the 2nd REQ cycle; late ack afterwards ignored.
        cur_id = 200;
        drive(tab[0]);
        @(posedge clk); #1;
        chk("mid_req1", 32'(bus.dmem_req), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.dmem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_be", 32'(bus.dmem_be), 32'd0);
        chk("mid_rst_load", ld, 32'd0);
        m_load = 32'h0;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        bus.dmem_rdata = 32'hFFFFFFFF; bus.dmem_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_req", 32'(bus.dmem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_load", ld, 32'd0);
        chk("late_ack_req2", 32'(bus.dmem_req), 32'd0);
        @(posedge clk); #1;
        cur_id = 201;
        run_txn(tab[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-003 SHALL have EX/MEM register inputs: EX_MEM_ALU_result_data in 32 (byte address); EX_MEM_Memory_Write_data_data in 32; EX_MEM_MemRead_data in 1; EX_MEM_MemWrite_data in 1; EX_MEM_StoreType_data in 2; EX_MEM_LoadType_data in 3; EX_MEM_ExcCode_data in 2.
REQ-004 SHALL have data-memory bus ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32 (word-aligned, bits[1:0]=00); dmem_be out 4; dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-005 SHALL have pipeline outputs: MEM_Stall out 1 (freezes EX_MEM and upstream); MEM_Load_data out 32; MEM_ExcCode out 2.

Function
REQ-006 SHALL decode StoreType: 00 SW, 01 SH, 10 SB, 11 treated as SW.
REQ-007 SHALL decode LoadType: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101-111 treated as LW.
REQ-008 SHALL define ExcCode: 00 none, 01 AdEL (load misaligned), 10 AdES (store misaligned), 11 bus timeout.
REQ-009 SHALL use an FSM with states IDLE, REQ, DONE; reset state IDLE.
REQ-010 Access = (MemRead or MemWrite) and EX_MEM_ExcCode_data==00 and address aligned (word: addr[1:0]==00; half: addr[0]==0; byte: always); MemWrite takes priority if both set.
REQ-011 IDLE: on access, MEM_Stall=1 and next state REQ; otherwise MEM_Stall=0 and stay IDLE.
REQ-012 REQ: dmem_req=1, dmem_addr={addr[31:2],2'b00}, dmem_we=MemWrite; MEM_Stall=1; on dmem_ack=1 go DONE, ack in the first REQ cycle allowed.
REQ-013 DONE: MEM_Stall=0, MEM_Load_data valid, unconditionally next state IDLE; minimum occupancy of an access is 3 cycles.
REQ-014 dmem_req, dmem_we, dmem_be SHALL be 0 in IDLE and DONE; dmem_wdata/dmem_addr are don't-care outside REQ but SHALL be stable throughout REQ.
REQ-015 Byte enables: SW 1111; SH 0011 if addr[1]=0 else 1100; SB one-hot 1<<addr[1:0]; loads 1111.
REQ-016 dmem_wdata: SW data; SH {2{data[15:0]}}; SB {4{data[7:0]}}.
REQ-017 On ack for a load, dmem_rdata SHALL be registered; MEM_Load_data = lane selected by addr[1:0], sign-extended (LH, LB) or zero-extended (LHU, LBU); LW full word.
REQ-018 MEM_Load_data SHALL hold its last value until the next load ack; reset value 0.
REQ-019 Timeout: 4-bit counter cleared on entry to REQ, incremented each REQ cycle without ack; at count 15 with no ack, abort: go DONE, MEM_ExcCode=11, no load data update.
REQ-020 MEM_ExcCode (combinational from registered state): upstream code passed through when nonzero; 01/10 for misaligned load/store in the same cycle, with no bus request issued and MEM_Stall=0; 11 during DONE after timeout; else 00.
REQ-021 dmem_ack outside REQ SHALL be ignored.
REQ-022 Inputs from EX_MEM SHALL be held stable by MEM_Stall; block uses them directly, no internal copy except rdata and timeout flag.

Reset
REQ-023 reset=0 at any time, including mid-REQ: state IDLE, counter 0, timeout flag 0, MEM_Load_data 0, dmem_req 0, dmem_we 0, dmem_be 0000, MEM_Stall 0, MEM_ExcCode 00 (upstream passthrough still combinational).
REQ-024 After reset release, first rising edge SHALL be able to start an access.

Verification
REQ-025 LW addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF -> Stall 1,1,0 over 3 cycles; dmem_be 1111; MEM_Load_data 0xDEADBEEF in DONE.
REQ-026 LB addr 0x103, rdata 0x80FF_FFFF -> MEM_Load_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102, rdata 0x8001_1234 -> 0x00008001.
REQ-027 SH addr 0x206, data 0x0000ABCD -> dmem_we 1, be 1100, wdata 0xABCDABCD, addr 0x204.
REQ-028 LW addr 0x101 -> MEM_ExcCode 01, dmem_req never 1, MEM_Stall 0; SH addr 0x3 -> 10.
REQ-029 LW with ack never asserted -> 15 REQ cycles then DONE with MEM_ExcCode 11, MEM_Load_data unchanged, Stall drops in DONE.
REQ-030 reset pulled low in 2nd REQ cycle -> dmem_req and MEM_Stall 0 immediately without clk edge; late ack after release ignored.
